// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC range-reduction control stage.
// Provides the quarter/full-turn constants, the FSM state enum and the quadrant type.
package cordic_pkg;

    localparam longint unsigned DEG90  = 64'd900_000_000;
    localparam longint unsigned DEG360 = 64'd3_600_000_000;

    typedef enum logic [2:0] {
        IDLE,
        WRAP,
        QUAD,
        DRAIN,
        RUN,
        OUT
    } state_t;

    typedef logic [1:0] quad_t;

endpackage

// File: rtl/cordic_range_ctrl_if.sv
// Handshake bundle for cordic_range_ctrl: angle in, sin/cos out, and core start/done.
// Ports: slave = control block side, master = environment (source, sink, core) side.
interface cordic_range_ctrl_if #(
    parameter int W = 32
);

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_angle;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_sine;
    logic signed [W-1:0] out_cosine;
    logic                cordic_s;
    logic        [W-1:0] cordic_angle;
    logic                cordic_done;
    logic signed [W-1:0] cordic_sine;
    logic signed [W-1:0] cordic_cosine;

    modport slave (
        input  in_valid, in_angle, out_ready,
        input  cordic_done, cordic_sine, cordic_cosine,
        output in_ready, out_valid, out_sine, out_cosine,
        output cordic_s, cordic_angle
    );

    modport master (
        output in_valid, in_angle, out_ready,
        output cordic_done, cordic_sine, cordic_cosine,
        input  in_ready, out_valid, out_sine, out_cosine,
        input  cordic_s, cordic_angle
    );

endinterface

// File: rtl/cordic_quad_fix.sv
// Maps first-quadrant core sine/cosine to the full circle by quadrant swap/negate.
// Ports: quad_i quadrant, s_i/c_i core sine/cosine, sin_o/cos_o signed results.
import cordic_pkg::*;

module cordic_quad_fix #(
    parameter int W = 32
) (
    input  quad_t               quad_i,
    input  logic signed [W-1:0] s_i,
    input  logic signed [W-1:0] c_i,
    output logic signed [W-1:0] sin_o,
    output logic signed [W-1:0] cos_o
);

    // Core outputs are non-negative, so negation never overflows.
    always_comb begin
        cos_o = c_i;
        sin_o = s_i;
        unique case (quad_i)
            2'd0: begin cos_o = c_i;  sin_o = s_i;  end
            2'd1: begin cos_o = -s_i; sin_o = c_i;  end
            2'd2: begin cos_o = -c_i; sin_o = -s_i; end
            2'd3: begin cos_o = s_i;  sin_o = -c_i; end
        endcase
    end

endmodule

// File: rtl/cordic_range_ctrl.sv
// Reduces a signed angle to [0,90deg), runs the CORDIC core, and fixes up the quadrant.
// Ports: clk, rst_n (async active-low), bus (slave side of cordic_range_ctrl_if).
import cordic_pkg::*;

module cordic_range_ctrl #(
    parameter int         W      = 32,
    parameter logic [W:0] DEG90  = (W+1)'(cordic_pkg::DEG90),
    parameter logic [W:0] DEG360 = (W+1)'(cordic_pkg::DEG360)
) (
    input logic                clk,
    input logic                rst_n,
    cordic_range_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic        [W:0]   acc_q, acc_d;
    quad_t               quad_q, quad_d;
    logic        [W-1:0] cang_q, cang_d;
    logic signed [W-1:0] sin_q, sin_d;
    logic signed [W-1:0] cos_q, cos_d;
    logic signed [W-1:0] fix_sin, fix_cos;

    cordic_quad_fix #(.W(W)) u_fix (
        .quad_i (quad_q),
        .s_i    (bus.cordic_sine),
        .c_i    (bus.cordic_cosine),
        .sin_o  (fix_sin),
        .cos_o  (fix_cos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            quad_q  <= '0;
            cang_q  <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            quad_q  <= quad_d;
            cang_q  <= cang_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.in_valid) state_d = WRAP;
            WRAP:  state_d = QUAD;
            QUAD:  if (acc_q < DEG90) state_d = DRAIN;
            // Wait for the core to leave done before starting it again.
            DRAIN: if (!bus.cordic_done) state_d = RUN;
            RUN:   if (bus.cordic_done) state_d = OUT;
            OUT:   if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        quad_d = quad_q;
        cang_d = cang_q;
        sin_d  = sin_q;
        cos_d  = cos_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    acc_d  = {bus.in_angle[W-1], bus.in_angle};
                    quad_d = '0;
                end
            end
            WRAP: begin
                // Input span of +-214.7deg needs at most one correction.
                if (acc_q[W]) begin
                    acc_d = acc_q + DEG360;
                end else if (acc_q >= DEG360) begin
                    acc_d = acc_q - DEG360;
                end
            end
            QUAD: begin
                if (acc_q >= DEG90) begin
                    acc_d  = acc_q - DEG90;
                    quad_d = quad_q + 2'd1;
                end else begin
                    cang_d = acc_q[W-1:0];
                end
            end
            RUN: begin
                if (bus.cordic_done) begin
                    sin_d = fix_sin;
                    cos_d = fix_cos;
                end
            end
            default: ;
        endcase
    end

    // in_ready is gated by rst_n so it stays low while reset is held.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && rst_n;
        bus.out_valid = (state_q == OUT);
        bus.cordic_s  = (state_q == RUN);
    end

    assign bus.cordic_angle = cang_q;
    assign bus.out_sine     = sin_q;
    assign bus.out_cosine   = cos_q;

endmodule

// File: tb/tb_cordic_range_ctrl.sv
// Self-checking bench for cordic_range_ctrl with a table-driven core stand-in.
// Covers quadrants, wrap, extreme angles, backpressure and reset mid-run.
module tb_cordic_range_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_range_ctrl_if #(.W(32)) bus ();

    cordic_range_ctrl #(.W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Core stand-in: fixed results per reduced angle, done held until s drops.
    logic        force_done = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_ang = 32'd0;
    int          unstable = 0;
    int          hs_cnt = 0;

    always @(posedge clk) begin
        if (m_done) begin
            if (!bus.cordic_s) m_done <= 1'b0;
        end else if (m_busy) begin
            if (!bus.cordic_s) begin
                m_busy <= 1'b0;
            end else begin
                if (bus.cordic_angle != m_ang) unstable <= unstable + 1;
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end else if (bus.cordic_s && !force_done) begin
            m_busy <= 1'b1;
            m_ang  <= bus.cordic_angle;
            m_cnt  <= 5;
        end
        if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    logic signed [31:0] core_s, core_c;
    always_comb begin
        core_s = 32'sd1234;
        core_c = 32'sd5678;
        case (m_ang)
            32'd0:           begin core_s = 32'sd0;       core_c = 32'sd10000000; end
            32'd300_000_000: begin core_s = 32'sd5000000; core_c = 32'sd8660254;  end
            32'd600_000_000: begin core_s = 32'sd8660254; core_c = 32'sd5000000;  end
            default: ;
        endcase
    end

    assign bus.cordic_done   = m_done | force_done;
    assign bus.cordic_sine   = core_s;
    assign bus.cordic_cosine = core_c;

    typedef struct {
        logic signed [31:0] ang;
        logic        [31:0] ca;
        logic signed [31:0] c;
        logic signed [31:0] s;
    } vec_t;

    vec_t v[11];

    task automatic check(input string nm, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("in_ready_timeout", 0, 1);
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("out_valid_timeout", 0, 1);
    endtask

    task automatic send(input logic signed [31:0] a, output bit ok);
        wait_ready(ok);
        if (ok) begin
            bus.in_valid = 1'b1;
            bus.in_angle = a;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic do_job(input vec_t t, input int idx);
        bit ok;
        send(t.ang, ok);
        if (ok) wait_out(ok);
        if (ok) begin
            check($sformatf("v%0d_cangle", idx), m_ang, t.ca);
            check($sformatf("v%0d_cos", idx), bus.out_cosine, t.c);
            check($sformatf("v%0d_sin", idx), bus.out_sine, t.s);
            check($sformatf("v%0d_stable", idx), unstable, 0);
            @(negedge clk);
            check($sformatf("v%0d_vdrop", idx), bus.out_valid, 0);
            check($sformatf("v%0d_idle", idx), bus.in_ready, 1);
        end
    endtask

    initial begin
        bit ok;
        int hs0;
        int sbad;
        logic signed [31:0] hs, hc;

        v[0]  = '{32'sd300_000_000,   32'd300_000_000, 32'sd8660254,   32'sd5000000};
        v[1]  = '{32'sd900_000_000,   32'd0,           32'sd0,         32'sd10000000};
        v[2]  = '{32'sd1_200_000_000, 32'd300_000_000, -32'sd5000000,  32'sd8660254};
        v[3]  = '{-32'sd300_000_000,  32'd600_000_000, 32'sd8660254,   -32'sd5000000};
        v[4]  = '{32'sd1_800_000_000, 32'd0,           -32'sd10000000, 32'sd0};
        v[5]  = '{32'sd600_000_000,   32'd600_000_000, 32'sd5000000,   32'sd8660254};
        v[6]  = '{32'sd2_147_483_647, 32'd347_483_647, -32'sd5678,     -32'sd1234};
        v[7]  = '{-32'sd900_000_000,  32'd0,           32'sd0,         -32'sd10000000};
        v[8]  = '{32'sh8000_0000,     32'd552_516_352, -32'sd1234,     32'sd5678};
        v[9]  = '{32'sd0,             32'd0,           32'sd10000000,  32'sd0};
        v[10] = '{-32'sd1_800_000_000, 32'd0,          -32'sd10000000, 32'sd0};

        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_cordic_s", bus.cordic_s, 0);
        check("rst_cangle", bus.cordic_angle, 0);
        check("rst_sin", bus.out_sine, 0);
        check("rst_cos", bus.out_cosine, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);

        for (int i = 0; i < 11; i++) do_job(v[i], i);

        // Backpressure with in_valid pulsing while busy.
        bus.out_ready = 1'b0;
        send(32'sd300_000_000, ok);
        bus.in_valid = 1'b1;
        bus.in_angle = 32'sd1_800_000_000;
        if (ok) wait_out(ok);
        if (ok) begin
            hs = bus.out_sine;
            hc = bus.out_cosine;
            check("bp_sin", hs, 32'sd5000000);
            check("bp_cos", hc, 32'sd8660254);
            hs0 = hs_cnt;
            for (int i = 0; i < 20; i++) begin
                bus.in_valid = i[0];
                @(negedge clk);
                check("bp_valid", bus.out_valid, 1);
                check("bp_hold_sin", bus.out_sine, hs);
                check("bp_hold_cos", bus.out_cosine, hc);
                check("bp_in_ready", bus.in_ready, 0);
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            @(negedge clk);
            check("bp_vdrop", bus.out_valid, 0);
            check("bp_idle", bus.in_ready, 1);
            repeat (3) @(negedge clk);
            check("bp_one_hs", hs_cnt - hs0, 1);
            check("bp_no_ghost", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;

        // Reset mid-RUN, then a job with the core still showing done.
        send(32'sd1_200_000_000, ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.cordic_s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("run_reached", ok, 1);
        @(negedge clk);
        force_done = 1'b1;
        rst_n = 1'b0;
        #1;
        check("ar_cordic_s", bus.cordic_s, 0);
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_in_ready", bus.in_ready, 0);
        check("ar_cangle", bus.cordic_angle, 0);
        check("ar_sin", bus.out_sine, 0);
        check("ar_cos", bus.out_cosine, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'sd300_000_000, ok);
        sbad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.cordic_s !== 1'b0) sbad++;
        end
        check("drain_s_low", sbad, 0);
        check("drain_cangle", bus.cordic_angle, 32'd300_000_000);
        force_done = 1'b0;
        wait_out(ok);
        if (ok) begin
            check("post_rst_cangle", m_ang, 32'd300_000_000);
            check("post_rst_cos", bus.out_cosine, 32'sd8660254);
            check("post_rst_sin", bus.out_sine, 32'sd5000000);
        end
        @(negedge clk);
        check("post_rst_idle", bus.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/cordic_range_ctrl.md
Name: cordic_range_ctrl

Overview:
- Upstream/downstream control stage wrapped around the iterative CORDIC core.
- The core only resolves first-quadrant angles and clamps its sine/cosine to non-negative values. This block accepts any signed angle, reduces it to [0, 90°), and runs the core through its s/done handshake.
- It then applies the quadrant swap and negation, and presents signed sine/cosine on a valid/ready output.
- Angle units are degrees x 1e7 (45° = 450_000_000). Result units are value x 1e7.

Parameters:
- W, 32, angle/result width.
- DEG90, 900_000_000, quarter turn in angle units.
- DEG360, 3_600_000_000, full turn in angle units; needs W+1 bits internally.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input angle valid.
- in_ready  out  1  block can accept an angle.
- in_angle  in  W  signed angle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sine  out  W  signed sine.
- out_cosine  out  W  signed cosine.
- cordic_s  out  1  core start/hold level.
- cordic_angle  out  W  reduced angle to the core.
- cordic_done  in  1  core done.
- cordic_sine  in  W  core sine.
- cordic_cosine  in  W  core cosine.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 during reset, 1 once in IDLE; out_valid=0, out_sine=0, out_cosine=0, cordic_s=0, cordic_angle=0, quadrant=0.
- IDLE: in_ready=1. On in_valid, latch in_angle sign-extended to W+1 bits into acc, clear quadrant, go to WRAP. in_ready=0 in every other state, so only one job is in flight.
- WRAP (1 cycle): if acc<0 then acc+=DEG360; else if acc>=DEG360 then acc-=DEG360. The input range of ±214.7° needs at most one correction. Go to QUAD.
- QUAD (1-4 cycles): each cycle, if acc>=DEG90 then acc-=DEG90 and quadrant+=1 (2-bit); otherwise drive cordic_angle=acc[W-1:0] and go to DRAIN.
- DRAIN: hold cordic_s=0 until cordic_done=0, then go to RUN. This guarantees the core has left its done state before a new start.
- RUN: cordic_s=1. cordic_angle stays stable for the whole of RUN, because the core reloads its angle while idle. On cordic_done=1, apply the quadrant fix-up below to cordic_sine/cordic_cosine, register out_sine/out_cosine, drop cordic_s, and go to OUT.
- Quadrant fix-up (s = core sine, c = core cosine):
  - q0: (cos, sin) = (c, s)
  - q1: (cos, sin) = (-s, c)
  - q2: (cos, sin) = (-c, -s)
  - q3: (cos, sin) = (s, -c)
  - Negation is two's complement on W bits; core outputs are non-negative, so no overflow is possible.
- OUT: out_valid=1 with data held stable until out_ready. On out_valid && out_ready, go to IDLE next cycle and drop out_valid; data may keep its value.
- Latency: 1 (accept) + 1 (WRAP) + 1-4 (QUAD) + 1+ (DRAIN) + core time + 1 (capture) cycles to out_valid.
- Boundaries:
  - Angle exactly 90°/180°/270° goes to the next quadrant with r=0.
  - Angle exactly 360° wraps to 0.
  - -0 does not exist.
  - out_ready held high: throughput is one result per job; no back-to-back overlap.
  - in_valid while busy is ignored and not latched.
  - rst_n low mid-RUN drops cordic_s immediately and discards the job. A core still in done is drained by the DRAIN state on the next job.

Decomposition:
- Shared package cordic_pkg:
  - constants DEG90 and DEG360;
  - state enum {IDLE, WRAP, QUAD, DRAIN, RUN, OUT};
  - 2-bit quadrant typedef.
- One natural sub-module, cordic_quad_fix: combinational swap/negate of (s, c) by quadrant, reusable and separately unit-testable.
- The reduction datapath and FSM stay in cordic_range_ctrl.

Test Plan:
- Angle 300_000_000 (30°) → q0, cordic_angle=300_000_000; out_cosine≈8_660_254, out_sine≈5_000_000 (±10_000 vs ideal).
- Angle 1_200_000_000 (120°) → 1 wrap-free QUAD step, cordic_angle=300_000_000; out_cosine≈-5_000_000, out_sine≈8_660_254.
- Angle -300_000_000 (-30°) → WRAP to 3_300_000_000, q3, cordic_angle=600_000_000; out_cosine≈8_660_254, out_sine≈-5_000_000.
- Angle 900_000_000 and 1_800_000_000 → q1 and q2 with cordic_angle=0; results (≈0, ≈10_000_000) and (≈-10_000_000, ≈0).
- out_ready held low 20 cycles after out_valid → outputs stable and in_ready=0 throughout. in_valid pulses during busy are ignored. Release → exactly one handshake, back to IDLE.
- rst_n pulsed low mid-RUN → all outputs zero asynchronously. The next 30° job completes correctly even with cordic_done still high at restart; cordic_s stays low until done=0.
